// File: rtl/result_order_fifo_if.sv
// Bundle of signals between the decoder / execution units and the in-order
// completion buffer. The slave side is the buffer itself; the master side is
// whatever drives issue and completion traffic (decoder + units, or a bench).
interface result_order_fifo_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    // control
    logic              flush;
    logic              issue_valid;
    logic [1:0]        issue_unit;

    // add/sub unit completion
    logic              add_done;
    logic [DATA_W-1:0] add_result;
    logic              add_overflow;

    // multiply unit completion
    logic              mul_done;
    logic [DATA_W-1:0] mul_result;
    logic              mul_overflow;

    // sine/cosine unit completion (never overflows)
    logic              sine_done;
    logic [DATA_W-1:0] sine_result;

    // retire stream and status
    logic              out_fifo_hold;
    logic [CW-1:0]     count;
    logic [DATA_W-1:0] result;
    logic              done;
    logic              overflow;
    logic              err;

    modport master (
        output flush, issue_valid, issue_unit,
        output add_done, add_result, add_overflow,
        output mul_done, mul_result, mul_overflow,
        output sine_done, sine_result,
        input  out_fifo_hold, count, result, done, overflow, err
    );

    modport slave (
        input  flush, issue_valid, issue_unit,
        input  add_done, add_result, add_overflow,
        input  mul_done, mul_result, mul_overflow,
        input  sine_done, sine_result,
        output out_fifo_hold, count, result, done, overflow, err
    );
endinterface

// File: rtl/result_order_fifo.sv
// In-order completion buffer for the FP co-processor. A tag FIFO records which
// unit every dispatched operation went to; each unit owns a one-entry holding
// register for its finished result. Results leave strictly in issue order, one
// per cycle, as a registered result/done/overflow stream.
module result_order_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               n_rst,
    result_order_fifo_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int NU = 3;
    localparam logic [1:0] UNIT_ILLEGAL = 2'd3;

    // ------------------------------------------------------------------
    // Unit-indexed views of the completion ports (0 add, 1 mul, 2 sine)
    // ------------------------------------------------------------------
    logic [NU-1:0]     unit_done;
    logic [NU-1:0]     unit_ovf;
    logic [DATA_W-1:0] unit_result [NU];

    assign unit_done      = {bus.sine_done, bus.mul_done, bus.add_done};
    assign unit_ovf       = {1'b0, bus.mul_overflow, bus.add_overflow};
    assign unit_result[0] = bus.add_result;
    assign unit_result[1] = bus.mul_result;
    assign unit_result[2] = bus.sine_result;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]        tag_mem [DEPTH];
    logic [PW-1:0]     wr_ptr_reg;
    logic [PW-1:0]     rd_ptr_reg;
    logic [CW-1:0]     count_reg;
    logic [CW-1:0]     count_next;

    logic [CW-1:0]     pend_reg [NU];
    logic [NU-1:0]     hold_valid_reg;
    logic [NU-1:0]     hold_ovf_reg;
    logic [DATA_W-1:0] hold_data_reg [NU];

    logic [DATA_W-1:0] result_reg;
    logic              overflow_reg;
    logic              done_reg;
    logic              err_reg;

    // ------------------------------------------------------------------
    // Decode of this cycle's events
    // ------------------------------------------------------------------
    logic              full;
    logic [1:0]        head_unit;
    logic              push;
    logic              issue_err;
    logic              retire;
    logic [NU-1:0]     unit_retire;
    logic [NU-1:0]     unit_capture;
    logic [NU-1:0]     unit_done_err;
    logic [NU-1:0]     unit_push;
    logic [DATA_W-1:0] retire_data;
    logic              retire_ovf;

    // Full is judged on the registered count, so a retire in the same cycle
    // does not make room for a push.
    assign full      = (count_reg == CW'(DEPTH));
    assign head_unit = tag_mem[rd_ptr_reg];
    assign push      = !bus.flush && bus.issue_valid &&
                       (bus.issue_unit != UNIT_ILLEGAL) && !full;
    assign issue_err = bus.issue_valid &&
                       ((bus.issue_unit == UNIT_ILLEGAL) || full);

    genvar gi;
    generate
        for (gi = 0; gi < NU; gi++) begin : gen_unit
            // The head entry belongs to this unit and its result is ready.
            assign unit_retire[gi]   = (count_reg != '0) &&
                                       (head_unit == 2'(gi)) &&
                                       hold_valid_reg[gi];
            // Accept a completion only if a tag is outstanding and the
            // holding register is free (or is being emptied right now).
            assign unit_capture[gi]  = unit_done[gi] &&
                                       (pend_reg[gi] != '0) &&
                                       (!hold_valid_reg[gi] || unit_retire[gi]);
            // Any completion that is not accepted is a protocol error.
            assign unit_done_err[gi] = unit_done[gi] && !unit_capture[gi];
            assign unit_push[gi]     = push && (bus.issue_unit == 2'(gi));
        end
    endgenerate

    assign retire = |unit_retire;

    // Select the holding register named by the FIFO head.
    always_comb begin
        retire_data = '0;
        retire_ovf  = 1'b0;
        for (int u = 0; u < NU; u++) begin
            if (unit_retire[u]) begin
                retire_data = hold_data_reg[u];
                retire_ovf  = hold_ovf_reg[u];
            end
        end
    end

    // Occupancy update: simultaneous push and pop leave it unchanged.
    always_comb begin
        count_next = count_reg;
        case ({push, retire})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Tag storage: plain memory, no reset needed because count guards reads.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr_reg] <= bus.issue_unit;
        end
    end

    // FIFO pointers, occupancy, retire stream and sticky error.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            result_reg   <= '0;
            overflow_reg <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            result_reg   <= '0;
            overflow_reg <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (retire) begin
                rd_ptr_reg   <= rd_ptr_reg + PW'(1);
                result_reg   <= retire_data;
                overflow_reg <= retire_ovf;
            end
            count_reg <= count_next;
            done_reg  <= retire;
            if (issue_err || (|unit_done_err)) begin
                err_reg <= 1'b1;
            end
        end
    end

    // Per-unit pending counters and holding registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            hold_valid_reg <= '0;
            hold_ovf_reg   <= '0;
            for (int u = 0; u < NU; u++) begin
                pend_reg[u]      <= '0;
                hold_data_reg[u] <= '0;
            end
        end else if (bus.flush) begin
            hold_valid_reg <= '0;
            hold_ovf_reg   <= '0;
            for (int u = 0; u < NU; u++) begin
                pend_reg[u]      <= '0;
                hold_data_reg[u] <= '0;
            end
        end else begin
            for (int u = 0; u < NU; u++) begin
                // A capture wins over the clear so a back-to-back completion
                // keeps the register valid while its predecessor retires.
                if (unit_capture[u]) begin
                    hold_valid_reg[u] <= 1'b1;
                    hold_data_reg[u]  <= unit_result[u];
                    hold_ovf_reg[u]   <= unit_ovf[u];
                end else if (unit_retire[u]) begin
                    hold_valid_reg[u] <= 1'b0;
                end

                case ({unit_push[u], unit_retire[u]})
                    2'b10:   pend_reg[u] <= pend_reg[u] + CW'(1);
                    2'b01:   pend_reg[u] <= pend_reg[u] - CW'(1);
                    default: pend_reg[u] <= pend_reg[u];
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.out_fifo_hold = full;
    assign bus.count         = count_reg;
    assign bus.result        = result_reg;
    assign bus.done          = done_reg;
    assign bus.overflow      = overflow_reg;
    assign bus.err           = err_reg;

endmodule

// File: tb/tb_result_order_fifo.sv
// Bench for result_order_fifo: directed scenarios followed by random traffic,
// all checked against a queue-based reference model and a retire scoreboard.
module tb_result_order_fifo;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;

    logic clk;
    logic n_rst;

    result_order_fifo_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

    result_order_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic              flush;
        logic              iv;
        logic [1:0]        unit;
        logic              add_d;
        logic [DATA_W-1:0] add_r;
        logic              add_o;
        logic              mul_d;
        logic [DATA_W-1:0] mul_r;
        logic              mul_o;
        logic              sin_d;
        logic [DATA_W-1:0] sin_r;
    } stim_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              ovf;
    } res_t;

    // reference model: issue-order queue of units and one result slot per unit
    logic [1:0]        tq [$];
    bit                hv [3];
    logic [DATA_W-1:0] hd [3];
    bit                ho [3];
    bit                m_err;
    logic [DATA_W-1:0] m_result;
    bit                m_ovf;
    res_t              exp_q [$];

    int  total = 0;
    int  bad   = 0;
    bit  mon_en = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int npend(input int u);
        int n = 0;
        foreach (tq[i]) if (int'(tq[i]) == u) n++;
        return n;
    endfunction

    task automatic model_clear();
        tq.delete();
        for (int u = 0; u < 3; u++) begin
            hv[u] = 0;
            hd[u] = '0;
            ho[u] = 0;
        end
        m_err    = 0;
        m_result = '0;
        m_ovf    = 0;
    endtask

    // Advance the model by one clock with the given inputs applied.
    task automatic model_step(input stim_t s);
        int                sz;
        int                head;
        bit                full;
        bit                ret;
        bit                dn  [3];
        bit                cap [3];
        logic [DATA_W-1:0] rv  [3];
        bit                ov  [3];
        if (s.flush) begin
            model_clear();
            return;
        end
        sz    = tq.size();
        full  = (sz == DEPTH);
        head  = (sz > 0) ? int'(tq[0]) : 3;
        ret   = (sz > 0) && (head < 3) && hv[head];
        dn[0] = s.add_d; dn[1] = s.mul_d; dn[2] = s.sin_d;
        rv[0] = s.add_r; rv[1] = s.mul_r; rv[2] = s.sin_r;
        ov[0] = s.add_o; ov[1] = s.mul_o; ov[2] = 0;
        for (int u = 0; u < 3; u++) begin
            cap[u] = 0;
            if (dn[u]) begin
                if (npend(u) == 0)                     m_err = 1;
                else if (hv[u] && !(ret && head == u)) m_err = 1;
                else                                   cap[u] = 1;
            end
        end
        if (s.iv && (s.unit == 2'd3 || full)) m_err = 1;
        if (ret) begin
            m_result = hd[head];
            m_ovf    = ho[head];
            exp_q.push_back('{data: hd[head], ovf: ho[head]});
            hv[head] = 0;
            void'(tq.pop_front());
        end
        for (int u = 0; u < 3; u++) begin
            if (cap[u]) begin
                hv[u] = 1;
                hd[u] = rv[u];
                ho[u] = ov[u];
            end
        end
        if (s.iv && s.unit != 2'd3 && !full) tq.push_back(s.unit);
    endtask

    task automatic apply(input stim_t s);
        bus.flush        = s.flush;
        bus.issue_valid  = s.iv;
        bus.issue_unit   = s.unit;
        bus.add_done     = s.add_d;
        bus.add_result   = s.add_r;
        bus.add_overflow = s.add_o;
        bus.mul_done     = s.mul_d;
        bus.mul_result   = s.mul_r;
        bus.mul_overflow = s.mul_o;
        bus.sine_done    = s.sin_d;
        bus.sine_result  = s.sin_r;
    endtask

    // Called at a falling edge; drives one cycle and returns at the next one.
    task automatic tick(input stim_t s);
        #1;
        apply(s);
        model_step(s);
        @(negedge clk);
    endtask

    task automatic do_reset();
        stim_t z;
        z = '0;
        #1;
        apply(z);
        n_rst = 1'b0;
        model_clear();
        @(negedge clk);
        #1;
        n_rst = 1'b1;
        @(negedge clk);
    endtask

    // Monitor: compares status every cycle and pops the scoreboard on retire.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("count",    64'(bus.count),         64'(tq.size()));
                chk("hold",     64'(bus.out_fifo_hold), 64'(tq.size() == DEPTH));
                chk("err",      64'(bus.err),           64'(m_err));
                chk("result",   64'(bus.result),        64'(m_result));
                chk("overflow", 64'(bus.overflow),      64'(m_ovf));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("done_expected", 64'(bus.done), 64'(1));
                    chk("sb_result",     64'(bus.result),   64'(e.data));
                    chk("sb_overflow",   64'(bus.overflow), 64'(e.ovf));
                end else begin
                    chk("done_idle", 64'(bus.done), 64'(0));
                end
                if (bus.done === 1'b1)
                    $display("retire: result=0x%08h overflow=%0b count=%0d",
                             bus.result, bus.overflow, bus.count);
            end
        end
    end

    // Stimulus
    initial begin
        stim_t s;
        stim_t z;
        z = '0;
        n_rst = 1'b0;
        apply(z);
        model_clear();
        repeat (3) @(negedge clk);
        #1 n_rst = 1'b1;
        @(negedge clk);
        mon_en = 1;

        // reset mid-stream
        s = '0; s.iv = 1; s.unit = 2'd0;
        tick(s); tick(s);
        s = '0; s.add_d = 1; s.add_r = 32'h1234_5678;
        tick(s);
        do_reset();
        chk("rst_count",    64'(bus.count),         64'(0));
        chk("rst_hold",     64'(bus.out_fifo_hold), 64'(0));
        chk("rst_result",   64'(bus.result),        64'(0));
        chk("rst_overflow", 64'(bus.overflow),      64'(0));
        chk("rst_done",     64'(bus.done),          64'(0));
        chk("rst_err",      64'(bus.err),           64'(0));
        s = '0; s.add_d = 1; s.add_r = 32'h1;
        tick(s);
        chk("rst_late_err", 64'(bus.err), 64'(1));
        tick(z);
        chk("rst_late_done", 64'(bus.done), 64'(0));

        // single op
        s = '0; s.flush = 1; tick(s);
        chk("flush_err", 64'(bus.err), 64'(0));
        s = '0; s.iv = 1; s.unit = 2'd0; tick(s);
        chk("single_count", 64'(bus.count), 64'(1));
        tick(z); tick(z);
        s = '0; s.add_d = 1; s.add_r = 32'h4040_0000; tick(s);
        chk("single_done_n1", 64'(bus.done), 64'(0));
        tick(z);
        chk("single_done_n2", 64'(bus.done),     64'(1));
        chk("single_result",  64'(bus.result),   64'(32'h4040_0000));
        chk("single_ovf",     64'(bus.overflow), 64'(0));
        chk("single_count0",  64'(bus.count),    64'(0));
        tick(z);
        chk("single_done_n3", 64'(bus.done), 64'(0));

        // reordering
        s = '0; s.iv = 1; s.unit = 2'd1; tick(s);
        s.unit = 2'd0; tick(s);
        s.unit = 2'd2; tick(s);
        s = '0; s.sin_d = 1; s.sin_r = 32'h3F00_0000; tick(s);
        s = '0; s.add_d = 1; s.add_r = 32'h4000_0000; tick(s);
        s = '0; s.mul_d = 1; s.mul_r = 32'h7F80_0000; s.mul_o = 1; tick(s);
        chk("reord_wait", 64'(bus.done), 64'(0));
        tick(z);
        chk("reord_mul",     64'(bus.result),   64'(32'h7F80_0000));
        chk("reord_mul_ovf", 64'(bus.overflow), 64'(1));
        tick(z);
        chk("reord_add",     64'(bus.result),   64'(32'h4000_0000));
        chk("reord_add_ovf", 64'(bus.overflow), 64'(0));
        chk("reord_add_dn",  64'(bus.done),     64'(1));
        tick(z);
        chk("reord_sin",     64'(bus.result),   64'(32'h3F00_0000));
        chk("reord_sin_dn",  64'(bus.done),     64'(1));
        tick(z);
        chk("reord_end", 64'(bus.done), 64'(0));

        // full / hold
        s = '0; s.iv = 1; s.unit = 2'd1;
        repeat (4) tick(s);
        chk("full_hold",  64'(bus.out_fifo_hold), 64'(1));
        chk("full_count", 64'(bus.count),         64'(4));
        chk("full_noerr", 64'(bus.err),           64'(0));
        tick(s);
        chk("full_err",    64'(bus.err),   64'(1));
        chk("full_count2", 64'(bus.count), 64'(4));
        s = '0; s.mul_d = 1; s.mul_r = 32'h1111_1111; tick(s);
        chk("full_hold_still", 64'(bus.out_fifo_hold), 64'(1));
        s = '0; s.iv = 1; s.unit = 2'd1; tick(s);
        chk("full_retire_dn",  64'(bus.done),          64'(1));
        chk("full_hold_off",   64'(bus.out_fifo_hold), 64'(0));
        chk("full_push_rej",   64'(bus.count),         64'(3));
        s = '0; s.flush = 1; tick(s);
        chk("flush2_count", 64'(bus.count), 64'(0));

        // simultaneous push/retire and back-to-back capture
        s = '0; s.iv = 1; s.unit = 2'd1; tick(s); tick(s);
        s = '0; s.mul_d = 1; s.mul_r = 32'hAAAA_0001; tick(s);
        chk("sim_count_pre", 64'(bus.count), 64'(2));
        s = '0; s.mul_d = 1; s.mul_r = 32'hBBBB_0002; s.iv = 1; s.unit = 2'd0; tick(s);
        chk("sim_count_same", 64'(bus.count),  64'(2));
        chk("sim_noerr",      64'(bus.err),    64'(0));
        chk("sim_first",      64'(bus.result), 64'(32'hAAAA_0001));
        tick(z);
        chk("sim_second",    64'(bus.result), 64'(32'hBBBB_0002));
        chk("sim_second_dn", 64'(bus.done),   64'(1));
        s = '0; s.add_d = 1; s.add_r = 32'hCCCC_0003; tick(s);
        tick(z); tick(z);
        chk("sim_drain", 64'(bus.count), 64'(0));

        // flush with pending work
        s = '0; s.iv = 1; s.unit = 2'd0; tick(s);
        s.unit = 2'd1; tick(s);
        s.unit = 2'd2; tick(s);
        s = '0; s.mul_d = 1; s.mul_r = 32'hDEAD_BEEF; tick(s);
        s = '0; s.flush = 1; tick(s);
        chk("flush_count", 64'(bus.count), 64'(0));
        chk("flush_err0",  64'(bus.err),   64'(0));
        s = '0; s.add_d = 1; s.add_r = 32'h5; tick(s);
        chk("flush_late_err", 64'(bus.err), 64'(1));
        tick(z);
        chk("flush_no_done", 64'(bus.done), 64'(0));

        // random traffic
        for (int c = 0; c < 2500; c++) begin
            int sz;
            int head;
            bit ret;
            bit fire;
            sz   = tq.size();
            head = (sz > 0) ? int'(tq[0]) : 3;
            ret  = (sz > 0) && (head < 3) && hv[head];
            if ($urandom_range(0, 999) < 3) begin
                do_reset();
                continue;
            end
            s = '0;
            if ((m_err && $urandom_range(0, 9) == 0) || $urandom_range(0, 199) == 0)
                s.flush = 1;
            s.iv   = ($urandom_range(0, 99) < 45);
            s.unit = ($urandom_range(0, 99) < 3) ? 2'd3 : 2'($urandom_range(0, 2));
            if (sz == DEPTH && $urandom_range(0, 7) != 0) s.iv = 0;
            for (int u = 0; u < 3; u++) begin
                fire = ((npend(u) - int'(hv[u])) > 0) &&
                       (!hv[u] || (ret && head == u)) &&
                       ($urandom_range(0, 99) < 40);
                if ($urandom_range(0, 199) == 0) fire = 1;
                case (u)
                    0: begin s.add_d = fire; s.add_r = $urandom; s.add_o = 1'($urandom_range(0, 1)); end
                    1: begin s.mul_d = fire; s.mul_r = $urandom; s.mul_o = 1'($urandom_range(0, 1)); end
                    default: begin s.sin_d = fire; s.sin_r = $urandom; end
                endcase
            end
            tick(s);
        end

        s = '0; s.flush = 1; tick(s);
        repeat (3) tick(z);
        chk("sb_empty", 64'(exp_q.size()), 64'(0));
        mon_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
